// File: rtl/mux_rr_onehot_reg_pkg.sv
// Shared definitions for the round-robin one-hot multiplexer:
// default sizes, output-register state encoding, one-hot helpers.
package mux_rr_onehot_reg_pkg;

    localparam int NCH_DEF = 5;
    localparam int DW_DEF  = 8;
    // Widest channel vector the helper functions accept.
    localparam int MAX_NCH = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Rotate the low n bits of a one-hot vector left by one; bit n-1 wraps to bit 0.
    function automatic logic [MAX_NCH-1:0] rotl1_onehot(input logic [MAX_NCH-1:0] v,
                                                        input int n);
        logic [MAX_NCH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_NCH; i++) begin
            if (i < n) begin
                r[(i + 1) % n] = v[i];
            end
        end
        return r;
    endfunction

    // True when at most one bit is set.
    function automatic logic is_onehot0(input logic [MAX_NCH-1:0] v);
        return (v & (v - MAX_NCH'(1))) == '0;
    endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin arbiter: grants the first request at or above
// the one-hot priority pointer, wrapping from the top channel to channel 0.
module rr_arb_onehot
    import mux_rr_onehot_reg_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] ptr,
    input  logic           enable,
    output logic [NCH-1:0] gnt
);

    // Requests are doubled so the wrapped search becomes a plain lowest-bit
    // search over bits at or above the pointer position.
    logic [2*NCH-1:0] w_req_dbl;
    logic [2*NCH-1:0] w_ptr_ext;
    logic [2*NCH-1:0] w_thermo;
    logic [2*NCH-1:0] w_cand;
    logic [2*NCH-1:0] w_first;

    assign w_req_dbl = {req, req};
    assign w_ptr_ext = {{NCH{1'b0}}, ptr};
    // All bits at or above the pointer position.
    assign w_thermo  = ~(w_ptr_ext - (2*NCH)'(1));
    assign w_cand    = w_req_dbl & w_thermo;
    // Isolate the lowest set candidate bit.
    assign w_first   = w_cand & (~w_cand + (2*NCH)'(1));

    // Fold the two halves back onto the channel vector.
    always_comb begin
        gnt = '0;
        if (enable) begin
            gnt = w_first[NCH-1:0] | w_first[2*NCH-1:NCH];
        end
    end

endmodule

// File: rtl/mux_rr_onehot_reg.sv
// N-channel multiplexer with internal round-robin selection and a
// single-entry valid/ready output register.
// Optional feature: define MUX_RR_LOCK_EN to add a lock input that keeps
// the arbiter on one channel until a grant is taken with lock low.
module mux_rr_onehot_reg
    import mux_rr_onehot_reg_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MUX_RR_LOCK_EN
    input  logic              lock,
`endif
    input  logic [NCH-1:0]    req,
    input  logic [DW*NCH-1:0] data_in,
    output logic [NCH-1:0]    gnt,
    output logic [DW-1:0]     data_out,
    output logic [NCH-1:0]    src,
    output logic              out_valid,
    input  logic              out_ready
);

    out_state_e       r_state;
    out_state_e       w_state_next;
    logic [NCH-1:0]   r_ptr;
    logic [NCH-1:0]   w_ptr_next;
    logic [NCH-1:0]   r_src;
    logic [DW-1:0]    r_data;
    logic [NCH-1:0]   w_req_eff;
    logic [NCH-1:0]   w_gnt;
    logic [NCH-1:0]   w_ptr_adv;
    logic [DW-1:0]    w_sel;
    logic             w_out_free;
    logic             w_load;
    logic [DW-1:0]    w_slice [NCH];

    // Split the concatenated input bus into per-channel words.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slice
            assign w_slice[gi] = data_in[DW*gi +: DW];
        end
    endgenerate

    assign w_out_free = (r_state == ST_EMPTY) || out_ready;
    assign w_ptr_adv  = NCH'(rotl1_onehot(MAX_NCH'(w_gnt), NCH));

`ifdef MUX_RR_LOCK_EN
    logic           r_locked;
    logic           w_locked_next;
    logic [NCH-1:0] r_lock_ch;
    logic [NCH-1:0] w_lock_ch_next;

    // While locked only the held channel may compete.
    assign w_req_eff = r_locked ? (req & r_lock_ch) : req;
`else
    assign w_req_eff = req;
`endif

    assign w_load = (|w_req_eff) && w_out_free;

    // Grant is suppressed during reset so nothing appears granted while held.
    rr_arb_onehot #(
        .NCH (NCH)
    ) u_arb (
        .req    (w_req_eff),
        .ptr    (r_ptr),
        .enable (w_load && rst_n),
        .gnt    (w_gnt)
    );

    // Select the granted channel's word; gnt is one-hot so OR-ing is exact.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt[k]) begin
                w_sel = w_sel | w_slice[k];
            end
        end
    end

    // Output-register occupancy: reload on grant, empty on accept without reload.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_next = ST_FULL;
            ST_FULL: begin
                if (w_load) begin
                    w_state_next = ST_FULL;
                end else if (out_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

`ifdef MUX_RR_LOCK_EN
    // Pointer only moves on the grant that leaves (or never enters) the lock.
    always_comb begin
        w_ptr_next     = r_ptr;
        w_locked_next  = r_locked;
        w_lock_ch_next = r_lock_ch;
        if (w_load) begin
            if (lock) begin
                w_locked_next  = 1'b1;
                w_lock_ch_next = w_gnt;
            end else begin
                w_locked_next  = 1'b0;
                w_ptr_next     = w_ptr_adv;
            end
        end
    end

    // Lock flag and held channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else begin
            r_locked  <= w_locked_next;
            r_lock_ch <= w_lock_ch_next;
        end
    end
`else
    // Pointer moves just past the granted channel on every grant.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_load) begin
            w_ptr_next = w_ptr_adv;
        end
    end
`endif

    // State and priority pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= NCH'(1);
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Output word and source tag; held unless a new word is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= '0;
        end else if (w_load) begin
            r_data <= w_sel;
            r_src  <= w_gnt;
        end
    end

    assign gnt       = w_gnt;
    assign data_out  = r_data;
    assign src       = r_src;
    assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_mux_rr_onehot_reg.sv
// Directed bench for mux_rr_onehot_reg (NCH=5, DW=8).
// The lock sequence is exercised only when MUX_RR_LOCK_EN is defined.
module tb_mux_rr_onehot_reg;
    import mux_rr_onehot_reg_pkg::*;

    localparam int NCH = 5;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req;
    logic [DW*NCH-1:0] data_in;
    logic [NCH-1:0]    gnt;
    logic [DW-1:0]     data_out;
    logic [NCH-1:0]    src;
    logic              out_valid;
    logic              out_ready;
`ifdef MUX_RR_LOCK_EN
    logic              lock;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit tb_done  = 1'b0;

    mux_rr_onehot_reg #(
        .NCH (NCH),
        .DW  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX_RR_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .data_out  (data_out),
        .src       (src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s val=%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*NCH-1:0] pack(input logic [7:0] d4, input logic [7:0] d3,
                                               input logic [7:0] d2, input logic [7:0] d1,
                                               input logic [7:0] d0);
        return {d4, d3, d2, d1, d0};
    endfunction

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !tb_done) begin
            check("gnt_onehot", 32'(is_onehot0(MAX_NCH'(gnt))), 32'd1);
        end
    end

    logic [NCH-1:0] fair_gnt [5];
    logic [7:0]     fair_dat [5];

    initial begin
        fair_gnt[0] = 5'b00001; fair_dat[0] = 8'h10;
        fair_gnt[1] = 5'b00010; fair_dat[1] = 8'h11;
        fair_gnt[2] = 5'b00100; fair_dat[2] = 8'h12;
        fair_gnt[3] = 5'b01000; fair_dat[3] = 8'h13;
        fair_gnt[4] = 5'b10000; fair_dat[4] = 8'h14;

        rst_n     = 1'b0;
        req       = '0;
        data_in   = '0;
        out_ready = 1'b0;
`ifdef MUX_RR_LOCK_EN
        lock      = 1'b0;
`endif

        // Reset values, including grant held low with requests present.
        #7;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(data_out),  32'h00);
        check("rst_src",   32'(src),       32'h00);
        req = 5'b11111;
        #1;
        check("rst_gnt",   32'(gnt),       32'h00);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_gnt",   32'(gnt),       32'h00);

        // Fairness: all channels requesting, pointer walks 0..4.
        data_in   = pack(8'h14, 8'h13, 8'h12, 8'h11, 8'h10);
        req       = 5'b11111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("fair_gnt", 32'(gnt), 32'(fair_gnt[i]));
            tick();
            check("fair_src",   32'(src),       32'(fair_gnt[i]));
            check("fair_data",  32'(data_out),  32'(fair_dat[i]));
            check("fair_valid", 32'(out_valid), 32'd1);
        end
        // Wrap: after channel 4, channel 0 comes first, then 4.
        req = 5'b10001;
        #1;
        check("wrap_gnt0", 32'(gnt), 32'h01);
        tick();
        check("wrap_src0", 32'(src), 32'h01);
        check("wrap_dat0", 32'(data_out), 32'h10);
        #1;
        check("wrap_gnt4", 32'(gnt), 32'h10);
        tick();
        check("wrap_src4", 32'(src), 32'h10);
        check("wrap_dat4", 32'(data_out), 32'h14);

        // Single request on channel 2 while full and accepted (reload).
        data_in = pack(8'h44, 8'h33, 8'hA5, 8'h11, 8'h00);
        req     = 5'b00100;
        #1;
        check("single_gnt", 32'(gnt), 32'h04);
        tick();
        check("single_data",  32'(data_out),  32'hA5);
        check("single_src",   32'(src),       32'h04);
        check("single_valid", 32'(out_valid), 32'd1);

        // Backpressure: full and not ready, channel 1 waiting.
        data_in   = pack(8'h44, 8'h33, 8'hA5, 8'h5C, 8'h00);
        req       = 5'b00010;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_gnt", 32'(gnt), 32'h00);
            tick();
            check("bp_data",  32'(data_out),  32'hA5);
            check("bp_src",   32'(src),       32'h04);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_gnt", 32'(gnt), 32'h02);
        tick();
        check("bp_rel_data", 32'(data_out), 32'h5C);
        check("bp_rel_src",  32'(src),      32'h02);

        // Drain: accepted with nothing pending.
        req = '0;
        #1;
        check("drain_gnt", 32'(gnt), 32'h00);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  32'(data_out),  32'h5C);
        check("drain_src",   32'(src),       32'h02);

        // Asynchronous reset in the middle of traffic.
        data_in = pack(8'h14, 8'h13, 8'h12, 8'h11, 8'h10);
        req     = 5'b11111;
        tick();
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(data_out),  32'h00);
        check("arst_src",   32'(src),       32'h00);
        check("arst_gnt",   32'(gnt),       32'h00);
        tick();
        check("arst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_gnt", 32'(gnt), 32'h01);
        tick();
        check("post_rst_src",  32'(src),      32'h01);
        check("post_rst_data", 32'(data_out), 32'h10);

`ifdef MUX_RR_LOCK_EN
        // Lock on channel 1 with every channel requesting.
        lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("lock_gnt", 32'(gnt), 32'h02);
            tick();
            check("lock_src", 32'(src), 32'h02);
        end
        lock = 1'b0;
        #1;
        check("unlock_gnt", 32'(gnt), 32'h02);
        tick();
        #1;
        check("after_lock_gnt", 32'(gnt), 32'h04);
        tick();
        check("after_lock_src", 32'(src), 32'h04);
`endif

        req     = '0;
        tb_done = 1'b1;
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
